// File: rtl/param_ram.sv
// param_ram: single-port synchronous RAM with a valid/ready request port, byte-lane writes,
// a 1..4 edge read pipeline and an optional zero-clear sweep after every reset.
module param_ram #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    isReading,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [0:DATA_WIDTH-1]   writeData,
  input  logic [0:DATA_WIDTH/8-1] byteEnable,
  output logic                    readValid,
  output logic [0:DATA_WIDTH-1]   readData
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rd_acc, wr_acc;
  logic [0:DATA_WIDTH-1] mem [DEPTH] = '{default: '0};

  logic                  vld_p  [READ_LATENCY];
  logic [0:DATA_WIDTH-1] data_p [READ_LATENCY];

  function automatic logic [0:DATA_WIDTH-1] merge_lanes(
    input logic [0:DATA_WIDTH-1] old_word,
    input logic [0:DATA_WIDTH-1] new_word,
    input logic [0:LANES-1]      lane_en
  );
    logic [0:DATA_WIDTH-1] res;
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign reqReady = (state == ST_READY) && !reset;
  assign rd_acc   = reqValid && reqReady && isReading;
  assign wr_acc   = reqValid && reqReady && !isReading;

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && (&clr_cnt)) state_nxt = ST_READY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Storage has no reset so contents survive it when the clear sweep is disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR)
        mem[clr_cnt] <= '0;
      else if (wr_acc)
        mem[address] <= merge_lanes(mem[address], writeData, byteEnable);
    end
  end

  // Stage 0 samples the array on the accepting edge; later stages shift on valid
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) vld_p[k] <= 1'b0;
    end else begin
      for (int k = 0; k < READ_LATENCY; k++)
        vld_p[k] <= (k == 0) ? rd_acc : vld_p[(k == 0) ? 0 : k - 1];
    end
  end

  // Only the output stage is cleared; it also holds the last result between reads
  always_ff @(posedge clk) begin
    for (int k = 0; k < READ_LATENCY; k++) begin
      if (k == READ_LATENCY - 1 && reset)
        data_p[k] <= '0;
      else if ((k == 0) ? rd_acc : vld_p[(k == 0) ? 0 : k - 1])
        data_p[k] <= (k == 0) ? mem[address] : data_p[(k == 0) ? 0 : k - 1];
    end
  end

  assign readValid = vld_p[READ_LATENCY-1];
  assign readData  = data_p[READ_LATENCY-1];

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: two param_ram instances (3-edge read with clear sweep, 1-edge read without)
// driven by shared directed and random traffic, checked every cycle against a behavioural model.
module tb_param_ram;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NDUT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            reqValid;
  logic            isReading;
  logic [AW-1:0]   address;
  logic [0:DW-1]   writeData;
  logic [0:DW/8-1] byteEnable;
  logic            rdy_a [NDUT];
  logic            vld_a [NDUT];
  logic [0:DW-1]   dat_a [NDUT];

  param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(rdy_a[0]), .isReading(isReading),
    .address(address), .writeData(writeData), .byteEnable(byteEnable),
    .readValid(vld_a[0]), .readData(dat_a[0])
  );

  param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(rdy_a[1]), .isReading(isReading),
    .address(address), .writeData(writeData), .byteEnable(byteEnable),
    .readValid(vld_a[1]), .readData(dat_a[1])
  );

  // Reference model state, one set per instance
  int          lat_m [NDUT] = '{3, 1};
  bit          clr_m [NDUT] = '{1'b1, 1'b0};
  logic [63:0] mem_m [NDUT][DEPTH];
  int          clr_left [NDUT];
  bit          sch_v [NDUT][8];
  logic [63:0] sch_d [NDUT][8];
  bit          exp_vld [NDUT];
  logic [63:0] exp_dat [NDUT];

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, act, exp);
    end
  endtask

  // Apply the rules of one rising edge to the model of instance d
  task automatic model_edge(input int d);
    int s;
    logic [63:0] wd;
    logic [7:0]  be;
    wd = writeData;
    be = byteEnable;
    if (reset) begin
      clr_left[d] = clr_m[d] ? DEPTH : 0;
      for (int i = 0; i < 8; i++) sch_v[d][i] = 1'b0;
      exp_dat[d] = '0;
    end else if (clr_left[d] > 0) begin
      clr_left[d]--;
      if (clr_left[d] == 0)
        for (int a = 0; a < DEPTH; a++) mem_m[d][a] = '0;
    end else if (reqValid) begin
      if (isReading) begin
        s = (edge_n + lat_m[d] - 1) % 8;
        sch_v[d][s] = 1'b1;
        sch_d[d][s] = mem_m[d][address];
      end else begin
        for (int b = 0; b < 8; b++)
          if (be[b]) mem_m[d][address][8*b +: 8] = wd[8*b +: 8];
      end
    end
    s = edge_n % 8;
    exp_vld[d] = sch_v[d][s];
    if (sch_v[d][s]) begin
      exp_dat[d]  = sch_d[d][s];
      sch_v[d][s] = 1'b0;
    end
  endtask

  task automatic check_dut(input int d);
    chk_val($sformatf("reqReady%0d", d), 64'(rdy_a[d]), 64'(!reset && clr_left[d] == 0));
    chk_val($sformatf("readValid%0d", d), 64'(vld_a[d]), 64'(exp_vld[d]));
    chk_val($sformatf("readData%0d", d), dat_a[d], exp_dat[d]);
  endtask

  task automatic tick();
    #2;
    if (chk_en)
      for (int d = 0; d < NDUT; d++) check_dut(d);
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < NDUT; d++) model_edge(d);
    #1;
  endtask

  task automatic drive(input bit rst, input bit vld, input bit rd, input int unsigned addr,
                       input logic [63:0] wd, input logic [7:0] be);
    reset      = rst;
    reqValid   = vld;
    isReading  = rd;
    address    = addr[AW-1:0];
    writeData  = wd;
    byteEnable = be;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 64'h0, 8'h00);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++)
      for (int a = 0; a < DEPTH; a++) mem_m[d][a] = '0;

    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    chk_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2, 64'h5555, 8'hFF);
    idle(20);

    // Preload all ones, then reset: the clear sweep must zero dut0 only
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b1, 1'b0, a, '1, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    for (int i = 0; i < 18; i++) drive(1'b0, 1'b1, 1'b0, i % DEPTH, 64'hC0FFEE, 8'hFF);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b1, 1'b1, a, 64'h0, 8'h00);
    idle(4);

    // Byte lanes: mask 0b10000001 touches the outermost bytes only
    drive(1'b0, 1'b1, 1'b0, 5, 64'h0011223344556677, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 5, 64'hAAAAAAAAAAAAAAAA, 8'h81);
    drive(1'b0, 1'b1, 1'b1, 5, 64'h0, 8'h00);
    chk_val("byteLane1", dat_a[1], 64'hAA112233445566AA);
    idle(2);
    chk_val("byteLane0", dat_a[0], 64'hAA112233445566AA);
    drive(1'b0, 1'b1, 1'b0, 5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 5, 64'h0, 8'h00);
    idle(3);

    // Pipelined reads of 1, 2, 3 followed by hold cycles
    for (int a = 1; a <= 3; a++) drive(1'b0, 1'b1, 1'b0, a, {$urandom, $urandom}, 8'hFF);
    for (int a = 1; a <= 3; a++) drive(1'b0, 1'b1, 1'b1, a, 64'h0, 8'h00);
    idle(6);

    // Write then read on the very next edge
    drive(1'b0, 1'b1, 1'b0, 7, 64'h1234, 8'hFF);
    drive(1'b0, 1'b1, 1'b1, 7, 64'h0, 8'h00);
    chk_val("wrThenRd1", dat_a[1], 64'h1234);
    idle(3);

    // Reset at clear count 9 restarts the sweep
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    idle(9);
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    idle(18);

    // Reset with reads in flight drops them
    drive(1'b0, 1'b1, 1'b1, 1, 64'h0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 2, 64'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    idle(4);

    // Contents survive reset in dut1; it is ready straight away
    drive(1'b0, 1'b1, 1'b0, 3, 64'hDEADBEEF, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 0, 64'h0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 3, 64'h0, 8'h00);
    chk_val("keepOnReset1", dat_a[1], 64'hDEADBEEF);
    idle(18);

    // Random mixed traffic with occasional resets
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), $urandom_range(1),
            $urandom_range(DEPTH - 1), {$urandom, $urandom}, 8'($urandom_range(255)));
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_ram.md
# param_ram

Parametrised single-port synchronous RAM for the datapath memory subsystem: the next generation of the fixed 2048 x 64 RAM. It replaces the bidirectional data bus with separate write/read buses and adds a valid/ready request handshake, per-byte write enables, a configurable read pipeline and an optional zero-clear sequence after reset. It sits between the CPU load/store unit and backing storage, and accepts at most one request per clock.

## Interface

- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address bits; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, edges from read acceptance to read data; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after each reset; 0 = contents survive reset.

Ports:

- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reqValid  input  1  request present this cycle.
- reqReady  output  1  block can accept a request this cycle.
- isReading  input  1  1 = read request, 0 = write request; meaningful only with reqValid.
- address  input  ADDR_WIDTH  word address.
- writeData  input  [0:DATA_WIDTH-1]  write word; bit 0 is the MSB, matching the existing [0:63] ordering.
- byteEnable  input  [0:DATA_WIDTH/8-1]  write lane mask; lane i covers writeData[8i:8i+7]; ignored on reads.
- readValid  output  1  one-cycle pulse marking readData as newly valid.
- readData  output  [0:DATA_WIDTH-1]  read result; holds its value until the next read completes.

## Operation

- The block has two states, CLEAR and READY.
- **Reset.** While reset is high, the block enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - Reset values: clear counter = 0, read pipeline flushed, readValid=0, readData=0.
  - reqReady is 0 during reset.
- **CLEAR.**
  - reqReady=0.
  - On each edge with reset low, the block writes 0 to word[counter] and increments the counter.
  - After the edge that writes word DEPTH-1, the block moves to READY.
  - Requests presented during CLEAR are ignored and not queued.
- **READY.**
  - reqReady=1 every cycle; the block never back-pressures.
  - A request is accepted on any edge where reqValid && reqReady.
- **Accepted write.**
  - For each lane i with byteEnable[i]=1, the lane is written from writeData.
  - Lanes with byteEnable[i]=0 keep their old value.
  - An all-zero mask is accepted and has no effect.
- **Accepted read.**
  - word[address] is sampled on the accepting edge and passes through READ_LATENCY-1 extra register stages.
- **Ordering.**
  - Requests complete in acceptance order.
  - A read accepted on the edge after a write to the same address returns the new data.
  - Back-to-back reads are fully pipelined: one result per cycle.
- **Reset mid-operation.**
  - In-flight reads are dropped: no readValid pulse for them.
  - A CLEAR in progress restarts at address 0.
  - With CLEAR_ON_RESET=0, contents are preserved through reset.
- **Initial contents.** All words are 0 at time zero, before any reset.
- Address wrap-around cannot occur: every address value maps to a word.

## Timing

- Read latency: for a read accepted at edge n, readValid=1 and readData valid in the cycle after edge n+READ_LATENCY-1, for exactly one cycle.
  - With READ_LATENCY=1 this is the cycle right after the accepting edge, as in the 2048 x 64 RAM.
- readData holds its last value after the readValid pulse, until the next read result or reset.
- Write latency: memory is updated at the accepting edge. No response is issued for writes.
- Clear duration: with reset low from edge r, reqReady stays 0 through edge r+DEPTH-1 and reads 1 from the cycle after edge r+DEPTH-1, i.e. DEPTH cycles of not-ready.
- CLEAR_ON_RESET=0: reqReady=1 in the first cycle after reset is sampled low.
- Throughput: 1 request per cycle in READY, with any mix of reads and writes.

## Test plan

- Clear sequence (ADDR_WIDTH=4, CLEAR_ON_RESET=1): preload words 0..15 with 0xFF..FF, pulse reset for 2 cycles -> reqReady low for exactly 16 cycles; reads of addresses 0..15 then return 0.
- Byte-enable write (DATA_WIDTH=64): write 0x0011223344556677 with mask all-ones to address 5, then write 0xAAAAAAAAAAAAAAAA with mask 0b10000001 -> read of address 5 returns 0xAA112233445566AA.
- Read pipelining (READ_LATENCY=3): reads of addresses 1, 2, 3 on consecutive edges n, n+1, n+2 -> readValid high in the cycles after edges n+2, n+3, n+4, with data in request order; readData held after the last pulse.
- Write-then-read: write 0x1234 to address 7 at edge n, read address 7 at edge n+1 -> returns 0x1234 (READ_LATENCY=1: readValid in the cycle after edge n+1).
- Reset mid-clear and mid-read: assert reset at clear count 9 -> clear restarts at address 0 and takes the full 16 cycles. Assert reset with 2 reads in flight -> no readValid pulses; readData=0.
- CLEAR_ON_RESET=0: write 0xDEADBEEF to address 3, pulse reset -> reqReady=1 in the first cycle after reset; read of address 3 returns 0xDEADBEEF. Requests with reqReady=0 leave memory unchanged.
